// File: rtl/window_former.sv
// ---------------------------------------------------------------------------
// window_former
// Turns WIN_SIZE vertically aligned row taps (coming from a row buffer) into a
// full WIN_SIZE x WIN_SIZE x CH_NUM pixel window. Only windows that fit fully
// inside the frame are emitted. Emission happens at a programmable stride,
// together with the window's output-map coordinates and an end-of-frame pulse.
//
// Ports
//   clk_i          clock, everything on the rising edge
//   reset_i        synchronous active-high reset
//   frame_h_i      rows per frame, sampled on frame_start_i
//   frame_w_i      pixels per row, sampled on frame_start_i
//   frame_start_i  marks the first beat of a frame (this or a later cycle)
//   din_vld_i      column beat valid
//   din_i          row taps, [0] = newest row
//   win_vld_o      one-cycle pulse; win_o/win_row_o/win_col_o are valid
//   win_o          win_o[r][c], r=0 newest row, c=0 newest column
//   win_row_o      output-map row index of the window
//   win_col_o      output-map column index of the window
//   frame_done_o   pulses with the last window of the frame (or one cycle
//                  after the last beat when the frame is too small)
// ---------------------------------------------------------------------------
module window_former #(
    parameter int FRAME_H_MAX = 224,
    parameter int FRAME_W_MAX = 224,
    parameter int DIN_WIDTH   = 8,
    parameter int WIN_SIZE    = 3,
    parameter int CH_NUM      = 3,
    parameter int STRIDE      = 1,
    localparam int HW = $clog2(FRAME_H_MAX) + 1,
    localparam int WW = $clog2(FRAME_W_MAX) + 1
) (
    input  logic                                                  clk_i,
    input  logic                                                  reset_i,
    input  logic [HW-1:0]                                         frame_h_i,
    input  logic [WW-1:0]                                         frame_w_i,
    input  logic                                                  frame_start_i,
    input  logic                                                  din_vld_i,
    input  logic [WIN_SIZE-1:0][CH_NUM-1:0][DIN_WIDTH-1:0]        din_i,
    output logic                                                  win_vld_o,
    output logic [WIN_SIZE-1:0][WIN_SIZE-1:0][CH_NUM-1:0][DIN_WIDTH-1:0] win_o,
    output logic [HW-1:0]                                         win_row_o,
    output logic [WW-1:0]                                         win_col_o,
    output logic                                                  frame_done_o
);

    // Phase counters need at least one bit even when STRIDE == 1.
    localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(STRIDE - 1);

    typedef logic [WIN_SIZE-1:0][WIN_SIZE-1:0][CH_NUM-1:0][DIN_WIDTH-1:0] win_t;

    logic [HW-1:0] frame_h_q, frame_h_d, row_cnt_q, row_cnt_d;
    logic [HW-1:0] out_row_q, out_row_d, win_row_q, win_row_d;
    logic [WW-1:0] frame_w_q, frame_w_d, col_cnt_q, col_cnt_d;
    logic [WW-1:0] out_col_q, out_col_d, win_col_q, win_col_d;
    logic [PW-1:0] row_ph_q, row_ph_d, col_ph_q, col_ph_d;
    logic          active_q, active_d, small_q, small_d;
    logic          win_vld_q, win_vld_d, frame_done_q, frame_done_d;
    win_t          sr_q, sr_d, sr_shift, win_q, win_d;

    // Effective state for this cycle: a frame_start overrides the stored
    // frame context so that a coincident beat lands at pixel (0,0).
    logic [HW-1:0] h_cur, r_cur, orow_cur;
    logic [WW-1:0] w_cur, c_cur, ocol_cur;
    logic [PW-1:0] rph_cur, cph_cur;
    logic          small_cur, accept, at_row, at_col, emit;
    logic          col_last, row_last, last_row_win, last_col_win;

    assign h_cur     = frame_start_i ? frame_h_i : frame_h_q;
    assign w_cur     = frame_start_i ? frame_w_i : frame_w_q;
    assign r_cur     = frame_start_i ? '0 : row_cnt_q;
    assign c_cur     = frame_start_i ? '0 : col_cnt_q;
    assign orow_cur  = frame_start_i ? '0 : out_row_q;
    assign ocol_cur  = frame_start_i ? '0 : out_col_q;
    assign rph_cur   = frame_start_i ? '0 : row_ph_q;
    assign cph_cur   = frame_start_i ? '0 : col_ph_q;
    assign small_cur = frame_start_i ? ((32'(frame_h_i) < WIN_SIZE) || (32'(frame_w_i) < WIN_SIZE))
                                     : small_q;

    assign accept   = din_vld_i & (active_q | frame_start_i);
    assign at_row   = 32'(r_cur) >= WIN_SIZE - 1;
    assign at_col   = 32'(c_cur) >= WIN_SIZE - 1;
    assign emit     = at_row & at_col & (rph_cur == '0) & (cph_cur == '0);
    assign col_last = (c_cur == w_cur - WW'(1));
    assign row_last = (r_cur == h_cur - HW'(1));
    // An emitting row/column is the last one when another stride step would
    // run past the frame edge.
    assign last_col_win = (32'(c_cur) + STRIDE) >= 32'(w_cur);
    assign last_row_win = (32'(r_cur) + STRIDE) >= 32'(h_cur);

    // Per-row column shift: tap enters at c=0, older columns move up.
    generate
        for (genvar gi = 0; gi < WIN_SIZE; gi++) begin : g_row
            assign sr_shift[gi][0] = din_i[gi];
            for (genvar gj = 1; gj < WIN_SIZE; gj++) begin : g_col
                assign sr_shift[gi][gj] = sr_q[gi][gj-1];
            end
        end
    endgenerate

    always_comb begin
        frame_h_d    = h_cur;
        frame_w_d    = w_cur;
        small_d      = small_cur;
        active_d     = active_q | frame_start_i;
        row_cnt_d    = r_cur;
        col_cnt_d    = c_cur;
        row_ph_d     = rph_cur;
        col_ph_d     = cph_cur;
        out_row_d    = orow_cur;
        out_col_d    = ocol_cur;
        sr_d         = sr_q;
        win_d        = win_q;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        win_vld_d    = 1'b0;
        frame_done_d = 1'b0;

        if (accept) begin
            sr_d = sr_shift;
            if (emit) begin
                win_vld_d    = 1'b1;
                win_d        = sr_shift;
                win_row_d    = orow_cur;
                win_col_d    = ocol_cur;
                frame_done_d = last_row_win & last_col_win;
            end
            if (col_last) begin
                col_cnt_d = '0;
                col_ph_d  = '0;
                out_col_d = '0;
                row_cnt_d = r_cur + HW'(1);
                if (at_row) begin
                    row_ph_d = (rph_cur == PH_LAST) ? '0 : rph_cur + PW'(1);
                    if (rph_cur == '0) begin
                        out_row_d = orow_cur + HW'(1);
                    end
                end
                if (row_last) begin
                    active_d = 1'b0;
                    // Frames smaller than the window still signal completion.
                    if (small_cur) begin
                        frame_done_d = 1'b1;
                    end
                end
            end else begin
                col_cnt_d = c_cur + WW'(1);
                if (at_col) begin
                    col_ph_d = (cph_cur == PH_LAST) ? '0 : cph_cur + PW'(1);
                end
                if (emit) begin
                    out_col_d = ocol_cur + WW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            frame_h_q    <= '0;
            frame_w_q    <= '0;
            small_q      <= 1'b0;
            active_q     <= 1'b0;
            row_cnt_q    <= '0;
            col_cnt_q    <= '0;
            row_ph_q     <= '0;
            col_ph_q     <= '0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            sr_q         <= '0;
            win_q        <= '0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            win_vld_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_h_q    <= frame_h_d;
            frame_w_q    <= frame_w_d;
            small_q      <= small_d;
            active_q     <= active_d;
            row_cnt_q    <= row_cnt_d;
            col_cnt_q    <= col_cnt_d;
            row_ph_q     <= row_ph_d;
            col_ph_q     <= col_ph_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            sr_q         <= sr_d;
            win_q        <= win_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            win_vld_q    <= win_vld_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign win_vld_o    = win_vld_q;
    assign win_o        = win_q;
    assign win_row_o    = win_row_q;
    assign win_col_o    = win_col_q;
    assign frame_done_o = frame_done_q;

endmodule
